// File: rtl/sound_cue_driver.sv
// sound_cue_driver: turns single-cycle game events into spaced trigger patterns
// for the speaker toggle block, with pending flags, priority and pre-emption.
//
// +--------------------------------------------------------------------------+
// | Module   : sound_cue_driver                                              |
// | Brief    : cue sequencer between game controller and speaker block       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module sound_cue_driver #(
  parameter int GAP_CYCLES   = 2000,
  parameter int BURST_CYCLES = 400,
  parameter int START_PULSES = 3,
  parameter int END_PULSES   = 2,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hit_evt_i,
  input  logic start_evt_i,
  input  logic end_evt_i,
  input  logic god_mode_i,
  output logic enable_o,
  output logic start_enable_o,
  output logic end_enable_o,
  output logic busy_o,
  output logic dropped_o
);

  localparam int             PL_W       = 8;
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] BURST_LOAD = CNT_W'(BURST_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;
  typedef enum logic [1:0] {CUE_HIT, CUE_START, CUE_END} cue_t;

  state_t            state_q;
  cue_t              cue_q;
  logic [PL_W-1:0]   left_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              pend_hit_q, pend_start_q, pend_end_q;
  logic              en_q, st_q, end_q, busy_q, dropped_q;

  logic              want_end_w, want_start_w, want_hit_w, any_w, preempt_w;
  cue_t              sel_cue_w;
  logic [PL_W-1:0]   sel_left_w;

  function automatic logic [2:0] cue_bits(input cue_t c);
    cue_bits = {c == CUE_HIT, c == CUE_START, c == CUE_END};
  endfunction

  assign want_end_w   = end_evt_i   | pend_end_q;
  assign want_start_w = start_evt_i | pend_start_q;
  assign want_hit_w   = hit_evt_i   | pend_hit_q;
  assign any_w        = want_end_w | want_start_w | want_hit_w;

  // End aborts hit/start cues, except in their trailing gap where it just pends.
  assign preempt_w = end_evt_i && (state_q != S_IDLE) && (cue_q != CUE_END) &&
                     !((state_q == S_GAP) && (left_q == '0));

  always_comb begin
    sel_cue_w  = CUE_HIT;
    sel_left_w = god_mode_i ? PL_W'(2) : PL_W'(1);
    if (want_end_w || (state_q != S_IDLE)) begin
      sel_cue_w  = CUE_END;
      sel_left_w = PL_W'(END_PULSES);
    end else if (want_start_w) begin
      sel_cue_w  = CUE_START;
      sel_left_w = PL_W'(START_PULSES);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cue_q        <= CUE_HIT;
      left_q       <= '0;
      cnt_q        <= '0;
      pend_hit_q   <= 1'b0;
      pend_start_q <= 1'b0;
      pend_end_q   <= 1'b0;
      en_q         <= 1'b0;
      st_q         <= 1'b0;
      end_q        <= 1'b0;
      busy_q       <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      dropped_q <= (hit_evt_i & pend_hit_q) | (start_evt_i & pend_start_q) |
                   (end_evt_i & pend_end_q);
      if ((state_q == S_IDLE && any_w) || preempt_w) begin
        state_q             <= S_PULSE;
        busy_q              <= 1'b1;
        cue_q               <= sel_cue_w;
        left_q              <= sel_left_w;
        cnt_q               <= (sel_cue_w == CUE_END) ? BURST_LOAD : '0;
        {en_q, st_q, end_q} <= cue_bits(sel_cue_w);
        // Losers of the priority race keep (or gain) their pending flag.
        pend_end_q   <= preempt_w ? pend_end_q : 1'b0;
        pend_start_q <= (sel_cue_w == CUE_END && !preempt_w) ?
                        (pend_start_q | start_evt_i) : 1'b0;
        pend_hit_q   <= (sel_cue_w == CUE_END && !preempt_w) ?
                        (pend_hit_q | hit_evt_i) : 1'b0;
      end else if (state_q != S_IDLE) begin
        pend_hit_q   <= pend_hit_q   | hit_evt_i;
        pend_start_q <= pend_start_q | start_evt_i;
        pend_end_q   <= pend_end_q   | end_evt_i;
        case (state_q)
          S_PULSE: begin
            if (cnt_q == '0) begin
              state_q             <= S_GAP;
              {en_q, st_q, end_q} <= 3'b000;
              cnt_q               <= GAP_LOAD;
              left_q              <= left_q - PL_W'(1);
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          S_GAP: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - CNT_W'(1);
            end else if (left_q != '0) begin
              state_q             <= S_PULSE;
              {en_q, st_q, end_q} <= cue_bits(cue_q);
              cnt_q               <= (cue_q == CUE_END) ? BURST_LOAD : '0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign enable_o       = en_q;
  assign start_enable_o = st_q;
  assign end_enable_o   = end_q;
  assign busy_o         = busy_q;
  assign dropped_o      = dropped_q;

endmodule

`default_nettype wire

// File: tb/tb_sound_cue_driver.sv
// tb_sound_cue_driver: directed cue scenarios; per-cycle expected outputs are
// queued as stimulus is applied and compared after each clock edge.
`default_nettype none

module tb_sound_cue_driver;

  logic clk = 1'b0;
  logic rst_n, hit_evt, start_evt, end_evt, god_mode;
  logic enable, start_enable, end_enable, busy, dropped;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0] v;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  sound_cue_driver #(
    .GAP_CYCLES(8), .BURST_CYCLES(4), .START_PULSES(3), .END_PULSES(2), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .hit_evt_i(hit_evt), .start_evt_i(start_evt), .end_evt_i(end_evt),
    .god_mode_i(god_mode),
    .enable_o(enable), .start_enable_o(start_enable), .end_enable_o(end_enable),
    .busy_o(busy), .dropped_o(dropped)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Cycle c's inputs are applied just after edge c; outputs of cycle c+1 are
  // observed just after edge c+1.
  task automatic run_case(input string name, input int n,
                          input logic [63:0] rstl, input logic [63:0] sh,
                          input logic [63:0] ss, input logic [63:0] se,
                          input logic god,
                          input logic [63:0] xen, input logic [63:0] xst,
                          input logic [63:0] xend, input logic [63:0] xbusy,
                          input logic [63:0] xdrop);
    exp_t       e;
    logic [4:0] obs;
    god_mode = god;
    for (int c = 0; c < n; c++) begin
      rst_n     = ~rstl[c];
      hit_evt   = sh[c];
      start_evt = ss[c];
      end_evt   = se[c];
      exp_q.push_back('{v: {xen[c+1], xst[c+1], xend[c+1], xbusy[c+1], xdrop[c+1]},
                        cyc: c + 1});
      @(posedge clk);
      #1;
      obs = {enable, start_enable, end_enable, busy, dropped};
      e   = exp_q.pop_front();
      checks++;
      assert (obs === e.v) else begin
        failures++;
        $error("FAIL %s cycle=%0d observed{en,st,end,busy,drop}=%b expected=%b",
               name, e.cyc, obs, e.v);
      end
    end
    rst_n = 1'b1; hit_evt = 1'b0; start_evt = 1'b0; end_evt = 1'b0; god_mode = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; hit_evt = 1'b0; start_evt = 1'b0; end_evt = 1'b0; god_mode = 1'b0;
    @(posedge clk);
    #1;

    run_case("reset", 16, rng(0, 2), rng(0, 2), '0, '0, 1'b0,
             '0, '0, '0, '0, '0);

    run_case("plain_hit", 24, '0, rng(10, 10), '0, '0, 1'b0,
             rng(11, 11), '0, '0, rng(11, 19), '0);

    run_case("god_hit", 33, '0, rng(10, 10), '0, '0, 1'b1,
             rng(11, 11) | rng(20, 20), '0, '0, rng(11, 28), '0);

    run_case("start_cue", 42, '0, '0, rng(10, 10), '0, 1'b0,
             '0, rng(11, 11) | rng(20, 20) | rng(29, 29), '0, rng(11, 37), '0);

    run_case("end_cue", 40, '0, '0, '0, rng(10, 10), 1'b0,
             '0, '0, rng(11, 14) | rng(23, 26), rng(11, 34), '0);

    run_case("end_preempts_start", 52, '0, '0, rng(10, 10), rng(22, 22), 1'b0,
             '0, rng(11, 11) | rng(20, 20), rng(23, 26) | rng(35, 38),
             rng(11, 46), '0);

    run_case("merge", 36, '0, rng(10, 10) | rng(13, 13) | rng(15, 15), '0, '0, 1'b0,
             rng(11, 11) | rng(21, 21), '0, '0, rng(11, 19) | rng(21, 29),
             rng(16, 16));

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sound_cue_driver.md
Name: sound_cue_driver

Overview:
- Cue sequencer that sits between the game controller and the speaker toggle block.
- Captures single-cycle game events (mole hit, game start, game over) and turns each one into a timed pattern of trigger pulses on the enable, start_enable and end_enable lines.
- Spaces successive triggers so that each audible burst can finish before the next trigger arrives.
- Queues, prioritises and pre-empts cues so that no two cue types ever drive the speaker block at the same time.

Parameters:
- GAP_CYCLES, 2000: silent cycles after every pulse or burst; must exceed the speaker block's 1000-cycle hold time.
- BURST_CYCLES, 400: width in cycles of each end_enable burst.
- START_PULSES, 3: number of start_enable pulses in the start cue.
- END_PULSES, 2: number of end_enable bursts in the end cue.
- CNT_W, 16: width of the gap/burst counter; must satisfy 2^CNT_W > max(GAP_CYCLES, BURST_CYCLES).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- hit_evt  in  1  single-cycle pulse: mole hit
- start_evt  in  1  single-cycle pulse: game start
- end_evt  in  1  single-cycle pulse: game over
- god_mode  in  1  level; doubles the hit cue
- enable  out  1  hit trigger to the speaker block
- start_enable  out  1  start trigger to the speaker block
- end_enable  out  1  end trigger to the speaker block
- busy  out  1  high while any cue is playing, including its trailing gap
- dropped  out  1  one-cycle flag: an event merged into an already-pending identical event

Behaviour:
- Reset (rst_n low at a clk edge):
  - state goes to IDLE; pending flags, counters and all outputs are cleared to 0.
  - Events present during reset are ignored.
  - Reset asserted mid-cue forces all outputs to 0 at that same edge.
- All outputs are registered. At most one of enable/start_enable/end_enable is high in any cycle.
- Pending flags: pend_hit, pend_start, pend_end.
  - A flag is set on its event.
  - If the event's flag is already set, the flag stays set and dropped pulses high for one cycle.
- Priority: end > start > hit. Dispatch is evaluated in IDLE, using the flags together with any same-cycle events.
- FSM states: IDLE, PULSE, GAP.
  - IDLE -> PULSE on the edge at which a qualifying event or flag is seen. Latency is 1 cycle: an event sampled at edge k gives output high in the cycle starting at edge k.
  - On dispatch:
    - clear the chosen flag;
    - latch cue type;
    - load pulses_left: hit = 1, or 2 if god_mode is sampled high at dispatch; start = START_PULSES; end = END_PULSES.
    - A dispatched start also clears pend_hit.
  - PULSE: the selected output is high for 1 cycle (hit/start) or BURST_CYCLES cycles (end), then -> GAP and pulses_left decrements.
  - GAP: all outputs low for GAP_CYCLES cycles. Then:
    - pulses_left > 0 -> PULSE;
    - otherwise -> IDLE. Pending flags are evaluated next cycle, so cues are separated by at least one IDLE cycle.
- busy = (state != IDLE).
- Pre-emption:
  - end_evt while playing hit or start: at the next edge, abort the current cue, clear pend_hit and pend_start, and start the end cue directly in PULSE.
  - start_evt while playing hit: set pend_start only; no pre-emption.
  - end_evt while playing end: set pend_end; the cue replays after completion.
- Events arriving during a cue's trailing GAP are treated as pending; they are not merged into the current cue.
- god_mode changes mid-cue have no effect until the next hit dispatch.
- Counter saturation is not reachable; the parameter constraint guarantees it.

Test Plan (GAP_CYCLES=8, BURST_CYCLES=4, START_PULSES=3, END_PULSES=2):
- Reset: rst_n low for cycles 0-2 with hit_evt high -> all outputs 0 and busy 0 through cycle 3; no cue starts after release.
- Plain hit: hit_evt in cycle 10 -> enable high in cycle 11 only; busy high in cycles 11-19; busy 0 in cycle 20.
- God-mode hit: god_mode=1, hit_evt in cycle 10 -> enable high in cycles 11 and 20; busy low from cycle 29.
- Start cue: start_evt in cycle 10 -> start_enable high in cycles 11, 20 and 29; busy low from cycle 38.
- End cue: end_evt in cycle 10 -> end_enable high in cycles 11-14 and 23-26; busy low from cycle 35.
- End pre-empts start: start_evt in cycle 10, end_evt in cycle 22 -> start_enable high in cycles 11 and 20 only; end_enable high in cycles 23-26 and 35-38; busy low from cycle 47.
- Merge: hit_evt in cycles 10, 13 and 15 -> dropped high in cycle 16; second hit cue enable high in cycle 21; no third cue.
